// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle core: branch condition codes, flag bit
// positions within the N/V/Z register, and the PC sequencer run state.
package cpu_pkg;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;

  typedef enum logic {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator over a registered N/V/Z flag vector.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       cond_true
);

  logic flag_n;
  logic flag_v;
  logic flag_z;

  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];
  assign flag_z = flags[FLAG_Z];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      COND_NE:  cond_true = ~flag_z;
      COND_EQ:  cond_true = flag_z;
      COND_GT:  cond_true = ~flag_z & ~flag_n;
      COND_LT:  cond_true = flag_n;
      // Z=1 or (Z=0 and N=0) reduces to Z or not N.
      COND_GE:  cond_true = flag_z | ~flag_n;
      COND_LE:  cond_true = flag_n | flag_z;
      COND_OV:  cond_true = flag_v;
      COND_UNC: cond_true = 1'b1;
      default:  cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flag_unit.sv
// Program counter, N/V/Z flag register and RUN/HALTED sequencer. Branches resolve
// against the registered flags, so a flag write is visible one instruction later.
module pc_flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned          WIDTH    = 16,
  parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       flag_in,
  input  logic [2:0]       flag_we,
  input  logic             branch,
  input  logic             branch_reg,
  input  logic [2:0]       cond,
  input  logic [8:0]       imm9,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             halt,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus2,
  output logic [2:0]       flags,
  output logic             taken,
  output logic             halted
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       flags_q, flags_d;

  logic             cond_true;
  logic             run;
  logic             advance;
  logic [WIDTH-1:0] imm_offset;
  logic [WIDTH-1:0] target;

  cond_eval u_cond_eval (
    .flags     (flags_q),
    .cond      (cond),
    .cond_true (cond_true)
  );

  assign run     = (state_q == PC_RUN);
  assign advance = run & ~stall;

  assign pc_plus2 = pc_q + WIDTH'(2);

  // Word offset: sign-extend imm9 and scale to bytes.
  assign imm_offset = {{(WIDTH - 9){imm9[8]}}, imm9} << 1;
  assign target     = branch_reg ? rs_val : (pc_plus2 + imm_offset);

  // Gated by rst_n so taken reads 0 while reset is held, whatever decode drives.
  assign taken = rst_n & (branch | branch_reg) & cond_true & advance;

  always_comb begin
    pc_d    = pc_q;
    flags_d = flags_q;
    state_d = state_q;
    if (advance) begin
      for (int i = 0; i < 3; i++) begin
        if (flag_we[i]) begin
          flags_d[i] = flag_in[i];
        end
      end
      if (halt) begin
        state_d = PC_HALTED;
      end else if (taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
      state_q <= PC_RUN;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      state_q <= state_d;
    end
  end

  assign pc     = pc_q;
  assign flags  = flags_q;
  assign halted = (state_q == PC_HALTED);

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed walk through the PC/flag behaviours followed by randomized traffic,
// all checked against a behavioural model of the program counter and flags.
module tb_pc_flag_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  flag_in;
  logic [2:0]  flag_we;
  logic        branch;
  logic        branch_reg;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] rs_val;
  logic        halt;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [2:0]  flags;
  logic        taken;
  logic        halted;

  int unsigned n_tests;
  int unsigned n_fail;

  // Reference state
  bit [15:0] m_pc;
  bit [2:0]  m_flags;
  bit        m_halt;

  pc_flag_unit #(
    .WIDTH    (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_in    (flag_in),
    .flag_we    (flag_we),
    .branch     (branch),
    .branch_reg (branch_reg),
    .cond       (cond),
    .imm9       (imm9),
    .rs_val     (rs_val),
    .halt       (halt),
    .stall      (stall),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .flags      (flags),
    .taken      (taken),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Condition truth table written directly from the condition-code definitions.
  function automatic bit cond_ok(input bit [2:0] c, input bit [2:0] f);
    bit n, v, z;
    n = f[0];
    v = f[1];
    z = f[2];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_flags = 3'b000;
    m_halt  = 1'b0;
  endtask

  task automatic drive_idle();
    flag_in    = 3'b000;
    flag_we    = 3'b000;
    branch     = 1'b0;
    branch_reg = 1'b0;
    cond       = 3'b000;
    imm9       = 9'h000;
    rs_val     = 16'h0000;
    halt       = 1'b0;
    stall      = 1'b0;
  endtask

  // One instruction: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic [2:0] fi, input logic [2:0] fw, input logic b,
                      input logic br, input logic [2:0] c, input logic [8:0] im,
                      input logic [15:0] rs, input logic h, input logic s);
    bit        exp_t;
    int        tgt;
    flag_in    = fi;
    flag_we    = fw;
    branch     = b;
    branch_reg = br;
    cond       = c;
    imm9       = im;
    rs_val     = rs;
    halt       = h;
    stall      = s;
    #1;
    exp_t = (b || br) && cond_ok(c, m_flags) && !m_halt && !s;
    // With halt and branch together, taken is unconstrained while running.
    if (!h || m_halt) check("taken", {31'b0, taken}, {31'b0, exp_t});
    check("pc_plus2", {16'b0, pc_plus2}, {16'b0, 16'(m_pc + 16'd2)});
    @(posedge clk);
    if (!s && !m_halt) begin
      for (int i = 0; i < 3; i++) if (fw[i]) m_flags[i] = fi[i];
      if (h) begin
        m_halt = 1'b1;
      end else if (exp_t) begin
        if (br) tgt = int'(rs);
        else    tgt = int'(m_pc) + 2 + int'($signed(im)) * 2;
        m_pc = 16'(tgt);
      end else begin
        m_pc = 16'(m_pc + 16'd2);
      end
    end
    #1;
    check("pc", {16'b0, pc}, {16'b0, m_pc});
    check("flags", {29'b0, flags}, {29'b0, m_flags});
    check("halted", {31'b0, halted}, {31'b0, m_halt});
  endtask

  task automatic idle_step();
    step(3'b000, 3'b000, 1'b0, 1'b0, 3'd0, 9'h000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic jump_to(input logic [15:0] addr);
    step(3'b000, 3'b000, 1'b0, 1'b1, 3'd7, 9'h000, addr, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse mid-cycle, with a taken branch decoded meanwhile.
  task automatic pulse_reset();
    branch = 1'b1;
    cond   = 3'd7;
    stall  = 1'b0;
    halt   = 1'b0;
    rst_n  = 1'b0;
    #1;
    model_reset();
    check("rst_pc", {16'b0, pc}, 32'h0000);
    check("rst_pc_plus2", {16'b0, pc_plus2}, 32'h0002);
    check("rst_flags", {29'b0, flags}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_taken", {31'b0, taken}, 32'h0);
    drive_idle();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    check("reset_pc", {16'b0, pc}, 32'h0000);
    check("reset_flags", {29'b0, flags}, 32'h0);
    check("reset_halted", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      idle_step();
      check("idle_pc", {16'b0, pc}, 32'(i * 2));
    end

    // Flag write then B EQ backwards by two words.
    jump_to(16'h0004);
    step(3'b100, 3'b111, 1'b0, 1'b0, 3'd0, 9'h000, 16'h0, 1'b0, 1'b0);
    check("z_set", {29'b0, flags}, 32'h4);
    step(3'b000, 3'b000, 1'b1, 1'b0, 3'd1, 9'h1FE, 16'h0, 1'b0, 1'b0);
    check("beq_back_pc", {16'b0, pc}, 32'h0004);

    // Same-cycle flag write must not affect the branch.
    step(3'b000, 3'b100, 1'b0, 1'b0, 3'd0, 9'h000, 16'h0, 1'b0, 1'b0);
    step(3'b100, 3'b100, 1'b1, 1'b0, 3'd0, 9'h010, 16'h0, 1'b0, 1'b0);
    check("bne_old_flags_pc", {16'b0, pc}, 32'h0028);
    step(3'b000, 3'b000, 1'b1, 1'b0, 3'd0, 9'h010, 16'h0, 1'b0, 1'b0);
    check("bne_new_flags_pc", {16'b0, pc}, 32'h002A);

    // Partial flag write, OV branch, then BR.
    step(3'b000, 3'b111, 1'b0, 1'b0, 3'd0, 9'h000, 16'h0, 1'b0, 1'b0);
    step(3'b111, 3'b010, 1'b0, 1'b0, 3'd0, 9'h000, 16'h0, 1'b0, 1'b0);
    check("v_only", {29'b0, flags}, 32'h2);
    step(3'b000, 3'b000, 1'b1, 1'b0, 3'd6, 9'h005, 16'h0, 1'b0, 1'b0);
    check("bov_pc", {16'b0, pc}, 32'h003A);
    step(3'b000, 3'b000, 1'b1, 1'b1, 3'd7, 9'h040, 16'h1234, 1'b0, 1'b0);
    check("br_pc", {16'b0, pc}, 32'h1234);

    // HLT: everything frozen until reset.
    jump_to(16'h0010);
    step(3'b000, 3'b000, 1'b1, 1'b0, 3'd7, 9'h020, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(3'($urandom), 3'b111, 1'b1, 1'($urandom), 3'd7, 9'($urandom), 16'h4444,
           1'($urandom), 1'b0);
      check("halt_pc", {16'b0, pc}, 32'h0010);
      check("halt_state", {31'b0, halted}, 32'h1);
    end
    pulse_reset();

    // Stall overrides a taken branch and halt.
    for (int i = 0; i < 3; i++) begin
      step(3'b111, 3'b111, 1'b1, 1'b0, 3'd7, 9'h030, 16'h0, 1'b0, 1'b1);
      check("stall_pc", {16'b0, pc}, 32'h0000);
    end
    step(3'b111, 3'b111, 1'b0, 1'b0, 3'd0, 9'h000, 16'h0, 1'b1, 1'b1);
    check("stall_halt", {31'b0, halted}, 32'h0);
    check("stall_flags", {29'b0, flags}, 32'h0);

    jump_to(16'hFFFE);
    idle_step();
    check("pc_wrap", {16'b0, pc}, 32'h0000);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (m_halt && $urandom_range(7) == 0) begin
        pulse_reset();
      end else begin
        step(3'($urandom), 3'($urandom), $urandom_range(2) == 0, $urandom_range(2) == 0,
             3'($urandom), 9'($urandom), 16'($urandom) & 16'hFFFE,
             $urandom_range(59) == 0, $urandom_range(5) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
